// File: rtl/alu_control_mc.sv
// Registered ALU control for the RV32IM pipeline: decodes {funct7, alu_op, funct3} into an
// ALU operation code and sequences multi-cycle M-extension ops with a busy request.
module alu_control_mc #(
  parameter int unsigned OP_W       = 5,
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic [6:0]      funct7_i,
  input  logic [2:0]      alu_op_i,
  input  logic [2:0]      funct3_i,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic [OP_W-1:0] alu_operation_o,
  output logic            valid_o,
  output logic            busy_o,
  output logic            illegal_o
);

  localparam int unsigned MaxLat = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxLat);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              valid_q, valid_d;
  logic              illegal_q, illegal_d;

  logic [4:0]        dec_code;
  logic              dec_illegal;
  logic              dec_multi;
  logic [CntW-1:0]   dec_cnt;

  always_comb begin
    dec_code    = 5'd0;
    dec_illegal = 1'b0;
    dec_multi   = 1'b0;
    dec_cnt     = '0;
    if (alu_op_i == 3'b000 && funct7_i == 7'b0000001) begin
      case (funct3_i)
        3'b000:  begin dec_code = 5'd16; dec_multi = 1'b1; dec_cnt = CntW'(MUL_CYCLES - 1); end
        3'b001:  begin dec_code = 5'd17; dec_multi = 1'b1; dec_cnt = CntW'(MUL_CYCLES - 1); end
        3'b100:  begin dec_code = 5'd18; dec_multi = 1'b1; dec_cnt = CntW'(DIV_CYCLES - 1); end
        3'b110:  begin dec_code = 5'd19; dec_multi = 1'b1; dec_cnt = CntW'(DIV_CYCLES - 1); end
        default: dec_illegal = 1'b1;
      endcase
    end else begin
      case (alu_op_i)
        3'b000: begin
          // R-type: only funct7[5] distinguishes the base-ISA variants
          case ({funct7_i[5], funct3_i})
            4'b0_000: dec_code = 5'd0;
            4'b1_000: dec_code = 5'd1;
            4'b0_110: dec_code = 5'd2;
            4'b0_111: dec_code = 5'd3;
            4'b0_100: dec_code = 5'd4;
            4'b0_001: dec_code = 5'd6;
            4'b0_101: dec_code = 5'd7;
            4'b1_101: dec_code = 5'd11;
            4'b0_010: dec_code = 5'd12;
            4'b0_011: dec_code = 5'd13;
            default:  dec_illegal = 1'b1;
          endcase
        end
        3'b001: begin
          case (funct3_i)
            3'b000:  dec_code = 5'd0;
            3'b110:  dec_code = 5'd2;
            3'b111:  dec_code = 5'd3;
            3'b100:  dec_code = 5'd4;
            default: dec_illegal = 1'b1;
          endcase
        end
        3'b010: dec_code = 5'd5;
        3'b011: dec_code = 5'd15;
        3'b100: dec_code = 5'd0;
        3'b101: begin
          case (funct3_i)
            3'b000:  dec_code = 5'd8;
            3'b001:  dec_code = 5'd9;
            default: dec_illegal = 1'b1;
          endcase
        end
        3'b110: dec_code = 5'd10;
        default: dec_code = 5'd0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    op_d      = op_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;
    if (flush_i) begin
      state_d   = StIdle;
      count_d   = '0;
      op_d      = '0;
      valid_d   = 1'b0;
      illegal_d = 1'b0;
    end else if (!stall_i) begin
      unique case (state_q)
        StIdle: begin
          op_d = OP_W'(dec_code);
          if (valid_i) illegal_d = dec_illegal;
          if (valid_i && dec_multi) begin
            count_d = dec_cnt;
            valid_d = 1'b0;
            state_d = StBusy;
          end else begin
            valid_d = valid_i;
          end
        end
        StBusy: begin
          count_d = count_q - CntW'(1);
          if (count_q == CntW'(1)) begin
            valid_d = 1'b1;
            state_d = StIdle;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      op_q      <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      op_q      <= op_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

  assign alu_operation_o = op_q;
  assign valid_o         = valid_q;
  assign busy_o          = (state_q == StBusy);
  assign illegal_o       = illegal_q;

endmodule

// File: tb/tb_alu_control_mc.sv
// Scoreboard bench for alu_control_mc: stimulus queues expected {code, illegal, edge} and a
// negedge monitor checks each valid_o pulse against the queue head.
module tb_alu_control_mc;
  localparam int unsigned OP_W       = 5;
  localparam int unsigned MUL_CYCLES = 2;
  localparam int unsigned DIV_CYCLES = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            valid_i = 1'b0;
  logic [6:0]      funct7_i = '0;
  logic [2:0]      alu_op_i = '0;
  logic [2:0]      funct3_i = '0;
  logic            stall_i = 1'b0;
  logic            flush_i = 1'b0;
  logic [OP_W-1:0] alu_operation_o;
  logic            valid_o;
  logic            busy_o;
  logic            illegal_o;

  alu_control_mc #(
    .OP_W       (OP_W),
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .valid_i         (valid_i),
    .funct7_i        (funct7_i),
    .alu_op_i        (alu_op_i),
    .funct3_i        (funct3_i),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .alu_operation_o (alu_operation_o),
    .valid_o         (valid_o),
    .busy_o          (busy_o),
    .illegal_o       (illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OP_W-1:0] code;
    logic            ill;
    int unsigned     edge_n;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && valid_o) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_valid", valid_o, 0);
      end else begin
        e = sb_q.pop_front();
        chk("code", alu_operation_o, e.code);
        chk("illegal", illegal_o, e.ill);
        chk("valid_edge", edge_cnt, e.edge_n);
        chk("busy_at_valid", busy_o, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] f7, input logic [2:0] op,
                       input logic [2:0] f3);
    valid_i  = v;
    funct7_i = f7;
    alu_op_i = op;
    funct3_i = f3;
  endtask

  // Result expected after the edge that is 'lat' edges from now
  task automatic expect_out(input logic [OP_W-1:0] code, input logic ill, input int unsigned lat);
    exp_t e;
    e.code   = code;
    e.ill    = ill;
    e.edge_n = edge_cnt + lat;
    sb_q.push_back(e);
  endtask

  task automatic send(input logic [6:0] f7, input logic [2:0] op, input logic [2:0] f3,
                      input logic [OP_W-1:0] code, input logic ill);
    drive(1'b1, f7, op, f3);
    expect_out(code, ill, 1);
    tick();
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && sb_q.size() > 0; i++) tick();
    tick();
    chk(name, sb_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    tick();
    chk("reset_op", alu_operation_o, 0);
    chk("reset_valid", valid_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_illegal", illegal_o, 0);
    reset = 1'b0;

    // Decode sweep, one per cycle
    send(7'b0100000, 3'b000, 3'b000, 5'd1, 1'b0);   // SUB
    send(7'b1111111, 3'b001, 3'b100, 5'd4, 1'b0);   // XORI, funct7 ignored
    send(7'b0100000, 3'b010, 3'b011, 5'd5, 1'b0);   // LUI
    send(7'b0000000, 3'b101, 3'b001, 5'd9, 1'b0);   // BNE
    send(7'b0000001, 3'b011, 3'b111, 5'd15, 1'b0);  // AUIPC, M-like funct7 ignored
    send(7'b0100000, 3'b000, 3'b101, 5'd11, 1'b0);  // SRA
    send(7'b0000000, 3'b000, 3'b011, 5'd13, 1'b0);  // SLTU
    send(7'b0000000, 3'b000, 3'b010, 5'd12, 1'b0);  // SLT
    send(7'b0000000, 3'b110, 3'b101, 5'd10, 1'b0);  // JAL
    send(7'b0000000, 3'b000, 3'b111, 5'd3, 1'b0);   // AND
    drive(1'b0, 7'b0, 3'b000, 3'b000);
    tick();
    drain("drain_sweep", 5);

    // MUL followed by back-to-back ADD held on the inputs
    drive(1'b1, 7'b0000001, 3'b000, 3'b000);
    expect_out(5'd16, 1'b0, MUL_CYCLES);
    tick();
    chk("mul_busy_n", busy_o, 1);
    chk("mul_valid_n", valid_o, 0);
    drive(1'b1, 7'b0000000, 3'b000, 3'b000);
    expect_out(5'd0, 1'b0, 2);
    tick();
    chk("mul_busy_n1", busy_o, 0);
    tick();
    drive(1'b0, 7'b0, 3'b000, 3'b000);
    chk("add_busy", busy_o, 0);
    drain("drain_mul", 5);

    // DIV with a 3-cycle stall in the middle
    drive(1'b1, 7'b0000001, 3'b000, 3'b100);
    expect_out(5'd18, 1'b0, DIV_CYCLES + 3);
    tick();
    drive(1'b0, 7'b0, 3'b000, 3'b000);
    tick();
    tick();
    stall_i = 1'b1;
    repeat (3) tick();
    chk("div_stall_busy", busy_o, 1);
    chk("div_stall_op", alu_operation_o, 18);
    chk("div_stall_valid", valid_o, 0);
    stall_i = 1'b0;
    tick();
    chk("div_op_held", alu_operation_o, 18);
    drain("drain_div", 20);

    // Flush beats stall mid-REM (count 4)
    drive(1'b1, 7'b0000001, 3'b000, 3'b110);
    tick();
    drive(1'b0, 7'b0, 3'b000, 3'b000);
    repeat (3) tick();
    chk("rem_busy", busy_o, 1);
    stall_i = 1'b1;
    flush_i = 1'b1;
    tick();
    chk("flush_busy", busy_o, 0);
    chk("flush_valid", valid_o, 0);
    chk("flush_op", alu_operation_o, 0);
    chk("flush_illegal", illegal_o, 0);
    stall_i = 1'b0;
    flush_i = 1'b0;
    repeat (10) tick();
    chk("flush_no_busy", busy_o, 0);

    // Illegal selectors, then a valid ADD clears illegal_o
    send(7'b0000001, 3'b000, 3'b010, 5'd0, 1'b1);
    send(7'b0100000, 3'b000, 3'b111, 5'd0, 1'b1);
    send(7'b0000000, 3'b000, 3'b000, 5'd0, 1'b0);
    drive(1'b0, 7'b0, 3'b000, 3'b000);
    tick();
    chk("illegal_cleared", illegal_o, 0);
    drain("drain_illegal", 5);

    // Reset held 2 cycles mid-DIV, then a normal ADD
    drive(1'b1, 7'b0000001, 3'b000, 3'b100);
    tick();
    drive(1'b0, 7'b0, 3'b000, 3'b000);
    tick();
    chk("div_busy_pre_reset", busy_o, 1);
    reset = 1'b1;
    tick();
    tick();
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_op", alu_operation_o, 0);
    chk("rst_illegal", illegal_o, 0);
    reset = 1'b0;
    send(7'b0000000, 3'b000, 3'b000, 5'd0, 1'b0);
    drive(1'b0, 7'b0, 3'b000, 3'b000);
    drain("drain_reset", 5);
    repeat (12) tick();
    chk("no_late_valid", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_control_mc.md
# alu_control_mc

Registered, multi-cycle-aware ALU control for the pipelined RV32IM core. It sits in the ID/EX boundary and decodes {funct7, ALU_Op, funct3} into an ALU operation code. It registers that code with a valid flag. For M-extension ops it runs a latency counter and raises a busy request to the hazard unit until the multiply/divide result is final.

## Interface
- OP_W, 5, width of the ALU operation code; must be ≥5.
- MUL_CYCLES, 2, execution cycles for MUL/MULH; must be ≥2.
- DIV_CYCLES, 8, execution cycles for DIV/REM; must be ≥2.
- clk  in  1  single clock; everything is updated on the rising edge.
- reset  in  1  synchronous, active-high; highest priority.
- valid_i  in  1  the decode-stage instruction is valid.
- funct7_i  in  7  instruction bits [31:25].
- alu_op_i  in  3  from main control: 000 R, 001 I-arith, 010 LUI, 011 AUIPC, 100 load, 101 branch, 110 JAL, 111 JALR.
- funct3_i  in  3  instruction bits [14:12].
- stall_i  in  1  downstream hold; freezes all state.
- flush_i  in  1  kill the current/in-flight op.
- alu_operation_o  out  OP_W  registered ALU operation code.
- valid_o  out  1  alu_operation_o is final for this instruction.
- busy_o  out  1  a multi-cycle op is in flight; upstream must hold.
- illegal_o  out  1  registered; the last accepted selector matched no entry.

## Operation
- Selector = {funct7_i[5], alu_op_i, funct3_i}. M-ops are recognised first: alu_op_i=000 and funct7_i=0000001.
  - funct3 000 → MUL 16.
  - funct3 001 → MULH 17.
  - funct3 100 → DIV 18.
  - funct3 110 → REM 19.
  - Other funct3 values → illegal.
- Legacy codes are unchanged:
  - ADD, ADDI, load, JALR → 0.
  - SUB → 1.
  - OR, ORI → 2.
  - AND, ANDI → 3.
  - XOR, XORI → 4.
  - LUI → 5.
  - SLL → 6.
  - SRL → 7.
  - BEQ → 8.
  - BNE → 9.
  - JAL (any funct3) → 10.
  - AUIPC (any funct3) → 15.
- New single-cycle codes:
  - SRA (1_000_101) → 11.
  - SLT (0_000_010) → 12.
  - SLTU (0_000_011) → 13.
- For I-type, load, LUI, AUIPC, branch, JAL and JALR, funct7 is ignored.
- Unmatched selector → code 0, illegal_o=1. illegal_o is only updated when valid_i=1 is accepted.
- Codes are zero-extended to OP_W.
- FSM states: IDLE and BUSY. busy_o = (state==BUSY).
- IDLE, on an edge with stall_i=0:
  - alu_operation_o ← decoded code.
  - If valid_i=1 and the op is multi-cycle: count ← LAT−1, valid_o ← 0, state ← BUSY. LAT is MUL_CYCLES or DIV_CYCLES.
  - Otherwise: valid_o ← valid_i.
- BUSY, on an edge with stall_i=0:
  - Inputs are ignored and count decrements.
  - The edge where count reaches 0 sets valid_o ← 1 and state ← IDLE.
  - alu_operation_o holds the M-op code throughout.
- valid_o after M-op completion is a one-cycle pulse. The next edge behaves as IDLE and accepts the new input.
- stall_i=1 (no flush): state, count and all outputs hold.
- flush_i=1 on any edge, in either state: state ← IDLE, valid_o ← 0, busy_o → 0, illegal_o ← 0, alu_operation_o ← 0, count ← 0.
  - Flush beats stall; reset beats flush.
- Reset values: state IDLE, alu_operation_o 0, valid_o 0, busy_o 0, illegal_o 0, count 0.
- Counter width is $clog2(max(MUL_CYCLES, DIV_CYCLES)). Decrement never wraps because BUSY exits at 0.

## Timing
- Single-cycle op: latency 1. Inputs sampled at edge N are on outputs after edge N.
- Multi-cycle op accepted at edge N:
  - busy_o=1 from after edge N through edge N+LAT−2.
  - valid_o=1 and busy_o=0 after edge N+LAT−1.
  - The earliest next acceptance is edge N+LAT.
- Each stalled edge extends every window above by one cycle.
- busy_o is a Moore output with no combinational path from inputs.

## Test plan
- Reset: hold reset 2 cycles mid-BUSY (DIV) → all outputs 0, state IDLE; the next ADD is accepted normally.
- Legacy plus new decode: sweep SUB, XORI, LUI, BNE, AUIPC, SRA, SLTU with valid_i=1 → codes 1, 4, 5, 9, 15, 11, 13, each one cycle after its edge; valid_o=1, busy_o=0.
- MUL with MUL_CYCLES=2, accepted at edge 10:
  - busy_o=1 after edge 10 only.
  - valid_o=1, code 16 after edge 11.
  - Back-to-back ADD presented is accepted at edge 12.
- DIV with DIV_CYCLES=8 plus stall: stall_i=1 for 3 cycles mid-op → valid_o rises 3 cycles later (after edge N+10); code 18 held throughout.
- Flush mid-REM (count=4) with stall_i=1 simultaneously → next edge: busy_o=0, valid_o=0, code 0; no later valid pulse.
- Illegal: M-op funct3=010, then alu_op=000 funct7=0100000 funct3=111 → code 0, illegal_o=1 for each. A following valid ADD clears illegal_o.
